rca_pipe_addsub: RTL and testbench
==================================

# rca_pipe_addsub

Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready handshake. It is the next generation of our fixed 4-bit, 4-stage pipelined RCA. Width and stage count are generic. It adds a subtract mode, a signed-overflow flag and backpressure. It sits on datapath operand buses where a long carry chain must be split across cycles to meet timing.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be a multiple of `STAGES`.
- `STAGES`, default 4: number of pipeline stages. Legal range 1..`WIDTH`. The chunk width is `CW = WIDTH/STAGES`.
- `clock` input, 1 bit: the single clock, rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: the operands are valid this cycle.
- `in_ready` output, 1 bit: the block accepts the operands this cycle.
- `a` input, `WIDTH` bits: operand A.
- `b` input, `WIDTH` bits: operand B.
- `cin` input, 1 bit: carry in. Used in add mode only.
- `sub` input, 1 bit: 0 selects A+B+cin; 1 selects A−B.
- `out_valid` output, 1 bit: the result is valid.
- `out_ready` input, 1 bit: the consumer takes the result.
- `s` output, `WIDTH` bits: sum or difference.
- `c_out` output, 1 bit: carry out of the MSB. In subtract mode, 1 means no borrow.
- `ovf` output, 1 bit: two's-complement signed overflow.

## Operation
- Subtract is computed as A + ~B + 1. In subtract mode `cin` is ignored. `b` and `sub` are sampled together with `a`.
- Stage k (k = 0..STAGES-1) adds bit chunk [k·CW +: CW] using the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Input skew: the chunks not yet consumed travel with the token in registers.
- Output deskew: the chunks already computed travel with the token in registers. All bits of a result leave together.
- The carry between stages is registered per stage.
- `ovf` is the XOR of the carry into the MSB and the carry out of the MSB. It is computed in the last stage.
- A transfer on the input occurs when `in_valid && in_ready`. A transfer on the output occurs when `out_valid && out_ready`.
- Global stall: `advance = !out_valid || out_ready`.
  - `in_ready = advance`. This is combinational, with no registered path from `out_ready`.
  - When `advance = 1`, every stage register loads from its predecessor. The stage-0 valid bit loads `in_valid`.
  - When `advance = 0`, all stage registers, including their valid bits and data, hold.
- Bubbles propagate as valid=0 entries. Bubbles are not squeezed out under a stall.
- The data registers of invalid entries may hold any value. Outputs are qualified only by `out_valid`.
- There is no state machine beyond the valid shift chain. One result is produced per cycle at full throughput.

## Timing
- Latency from input transfer to `out_valid` is exactly `STAGES` cycles, provided there is no stall.
- Throughput is 1 result per cycle while `out_ready` = 1.
- Reset values:
  - `out_valid` = 0.
  - `s` = 0.
  - `c_out` = 0.
  - `ovf` = 0.
  - All internal valid, data and carry registers = 0.
  - `in_ready` = 1 as soon as `reset_n` is low or the pipe is empty.
- Reset mid-operation: all in-flight tokens are dropped immediately and asynchronously. The first input accepted after `reset_n` rises appears `STAGES` cycles later.
- A stall during a cycle holds `s`, `c_out`, `ovf` and `out_valid` stable. That is, the outputs do not change while `out_valid && !out_ready`.
- Simultaneous output drain and input accept is legal. With `out_ready` = 1 and `in_valid` = 1 every cycle, no cycle is lost.
- With `STAGES` = 1, the block degenerates to a single registered WIDTH-bit adder with latency 1.
- Wrap-around is modular 2^WIDTH. Carry and overflow are reported, never saturated.

## Structure
- No shared package types are required.
- Add `RCA_MAX_STAGES` and a `WIDTH % STAGES == 0` elaboration check to the common datapath constants package.
- One sub-module, `rca_chunk`, parametrised by `CW`. It is purely combinational: a ripple of full adders with ports `x`, `y`, `ci`, `sum`, `co`, `c_msb_in`.
- The top level instantiates `STAGES` copies in a generate loop, plus the skew/deskew and valid registers.

## Test plan
All scenarios use `WIDTH`=16 and `STAGES`=4 unless stated otherwise.
1. Add: a=0x1234, b=0x0F0F, cin=1, sub=0. Required: after 4 cycles, s=0x2144, c_out=0, ovf=0.
2. Sub and signed overflow:
   - a=0x0005, b=0x0007, sub=1 → s=0xFFFE, c_out=0 (borrow), ovf=0.
   - a=0x7FFF, b=0x0001, sub=0 → s=0x8000, ovf=1.
   - a=0xFFFF, b=0x0001, cin=0 → s=0x0000, c_out=1, ovf=0.
3. Streaming: drive 20 back-to-back random operands with `out_ready`=1. Required: 20 results in order, one per cycle, starting at cycle 4, all matching the reference model.
4. Backpressure: while streaming, drop `out_ready` for 3 cycles. Required:
   - `in_ready` = 0 during the stall.
   - The outputs hold stable during the stall.
   - No token is lost or duplicated, and order is preserved.
5. Reset mid-flight: with 3 tokens in the pipe, pulse `reset_n` low for 1 ns between clock edges. Required:
   - `out_valid` = 0 immediately.
   - No stale result emerges afterwards.
   - The next input appears after exactly 4 cycles.
6. Degenerate configuration: `WIDTH`=8, `STAGES`=1 and `WIDTH`=8, `STAGES`=8. Required for both: exhaustive a, b, cin, sub sweep matches the model, with latency 1 and 8 respectively.

Source files
------------

// File: rtl/rca_pipe_addsub_pkg.sv
// Common datapath constants for the pipelined ripple-carry adder/subtractor.
// Holds the stage-count ceiling and the elaboration-time configuration check.
package rca_pipe_addsub_pkg;

    localparam int RCA_MAX_STAGES = 64;

    function automatic bit rca_cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && (stages <= RCA_MAX_STAGES)
            && (width % stages == 0);
    endfunction

endpackage

// File: rtl/rca_pipe_addsub_chunk.sv
// Purely combinational CW-bit ripple of full adders, one per pipeline stage.
// c_msb_in exposes the carry into the top bit so the last stage can form ovf.
module rca_chunk
    import rca_pipe_addsub_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          ci,
    output logic [CW-1:0] sum,
    output logic          co,
    output logic          c_msb_in
);

    logic [CW:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CW; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co       = c[CW];
    assign c_msb_in = c[CW-1];

endmodule

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor with a global-stall valid/ready handshake.
// Each stage consumes the lowest remaining operand chunk and shifts its sum chunk in at the top.
module rca_pipe_addsub
    import rca_pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    if (!rca_cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("rca_pipe_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic             advance;
    logic [WIDTH-1:0] y_eff;
    logic             c_eff;

    // Stage inputs (from the predecessor register) and combinational stage results
    logic             vld_in [STAGES];
    logic [WIDTH-1:0] x_in   [STAGES];
    logic [WIDTH-1:0] y_in   [STAGES];
    logic             c_in   [STAGES];
    logic [CW-1:0]    sum_c  [STAGES];
    logic             co_c   [STAGES];
    logic             cmsb_c [STAGES];
    logic [WIDTH-1:0] x_nxt  [STAGES];

    // Pipeline registers: x_p mixes finished sum chunks (top) and unconsumed A chunks (bottom)
    logic             vld_p  [STAGES];
    logic [WIDTH-1:0] x_p    [STAGES];
    logic [WIDTH-1:0] y_p    [STAGES];
    logic             c_p    [STAGES];
    logic             ovf_p;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign y_eff    = sub ? ~b : b;
    assign c_eff    = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign vld_in[k] = in_valid;
            assign x_in[k]   = a;
            assign y_in[k]   = y_eff;
            assign c_in[k]   = c_eff;
        end else begin : g_next
            assign vld_in[k] = vld_p[k-1];
            assign x_in[k]   = x_p[k-1];
            assign y_in[k]   = y_p[k-1];
            assign c_in[k]   = c_p[k-1];
        end

        rca_chunk #(.CW(CW)) u_chunk (
            .x        (x_in[k][CW-1:0]),
            .y        (y_in[k][CW-1:0]),
            .ci       (c_in[k]),
            .sum      (sum_c[k]),
            .co       (co_c[k]),
            .c_msb_in (cmsb_c[k])
        );

        assign x_nxt[k] = (x_in[k] >> CW) | (WIDTH'(sum_c[k]) << (WIDTH - CW));
    end

    // Stage boundary registers: everything holds together when the output is stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                x_p[k]   <= '0;
                y_p[k]   <= '0;
                c_p[k]   <= 1'b0;
            end
            ovf_p <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= vld_in[k];
                x_p[k]   <= x_nxt[k];
                y_p[k]   <= y_in[k] >> CW;
                c_p[k]   <= co_c[k];
            end
            ovf_p <= co_c[STAGES-1] ^ cmsb_c[STAGES-1];
        end
    end

    assign out_valid = vld_p[STAGES-1];
    assign s         = x_p[STAGES-1];
    assign c_out     = c_p[STAGES-1];
    assign ovf       = ovf_p;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Bench for rca_pipe_addsub: directed and random traffic on a 16/4 instance,
// plus two 8-bit degenerate instances (1 and 8 stages) swept against an arithmetic model.
module tb_rca_pipe_addsub;

    localparam int W = 16;
    localparam int S = 4;
    localparam int DG_N = 3 * 16 * 256;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n, in_valid, in_ready, cin, sub, out_valid, out_ready, c_out, ovf;
    logic [W-1:0]  a, b, s;

    logic          dg_valid, dg_cin, dg_sub;
    logic [7:0]    dg_a, dg_b;
    logic          r1_ready, o1_valid, o1_c, o1_ovf;
    logic [7:0]    o1_s;
    logic          r8_ready, o8_valid, o8_c, o8_ovf;
    logic [7:0]    o8_s;

    rca_pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c_out(c_out), .ovf(ovf)
    );

    rca_pipe_addsub #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clock(clock), .reset_n(reset_n), .in_valid(dg_valid), .in_ready(r1_ready),
        .a(dg_a), .b(dg_b), .cin(dg_cin), .sub(dg_sub), .out_valid(o1_valid), .out_ready(1'b1),
        .s(o1_s), .c_out(o1_c), .ovf(o1_ovf)
    );

    rca_pipe_addsub #(.WIDTH(8), .STAGES(8)) dut_s8 (
        .clock(clock), .reset_n(reset_n), .in_valid(dg_valid), .in_ready(r8_ready),
        .a(dg_a), .b(dg_b), .cin(dg_cin), .sub(dg_sub), .out_valid(o8_valid), .out_ready(1'b1),
        .s(o8_s), .c_out(o8_c), .ovf(o8_ovf)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Result = {ovf, c_out, s[15:0]} from plain integer arithmetic on w-bit operands
    function automatic logic [17:0] ref_model(input int w, input logic [15:0] x, input logic [15:0] y,
                                              input logic ci, input logic op);
        longint ux, uy, mask, half, full, sx, sy, sr, r;
        logic carry;
        logic [17:0] res;
        ux   = longint'(x);
        uy   = longint'(y);
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sx   = (ux >= half) ? ux - 2 * half : ux;
        sy   = (uy >= half) ? uy - 2 * half : uy;
        if (op) begin
            r     = (ux - uy) & mask;
            carry = (ux >= uy);
            sr    = sx - sy;
        end else begin
            full  = ux + uy + longint'(ci);
            r     = full & mask;
            carry = ((full >> w) & 1) != 0;
            sr    = sx + sy + longint'(ci);
        end
        res        = '0;
        res[15:0]  = r[15:0];
        res[16]    = carry;
        res[17]    = (sr > half - 1) || (sr < -half);
        return res;
    endfunction

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          cyc;
        int          stl;
    } tok_t;

    tok_t        exp_q[$];
    int          cyc = 0;
    int          stall_cnt = 0;
    bit          mon_en = 1'b0;
    bit          prev_stall = 1'b0;
    bit          cur_stall;
    logic [15:0] prev_s;
    logic        prev_c, prev_o, prev_v;
    tok_t        m_tok;
    logic [17:0] m_r;

    // Scoreboard: accepted inputs queue model results; every output transfer pops one
    always @(negedge clock) begin
        cyc++;
        if (mon_en) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                chk("out_has_token", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    m_tok = exp_q.pop_front();
                    chk("stream_s", 32'(s), 32'(m_tok.s));
                    chk("stream_c_out", 32'(c_out), 32'(m_tok.c));
                    chk("stream_ovf", 32'(ovf), 32'(m_tok.o));
                    chk("stream_latency", 32'(cyc - m_tok.cyc - S), 32'(stall_cnt - m_tok.stl));
                end
            end
            if (prev_stall) begin
                chk("hold_s", 32'(s), 32'(prev_s));
                chk("hold_c_out", 32'(c_out), 32'(prev_c));
                chk("hold_ovf", 32'(ovf), 32'(prev_o));
                chk("hold_out_valid", 32'(out_valid), 32'(prev_v));
            end
            cur_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            if (cur_stall) chk("in_ready_stall", 32'(in_ready), 32'd0);
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                m_r       = ref_model(W, a, b, cin, sub);
                m_tok.s   = m_r[15:0];
                m_tok.c   = m_r[16];
                m_tok.o   = m_r[17];
                m_tok.cyc = cyc;
                m_tok.stl = stall_cnt;
                exp_q.push_back(m_tok);
            end
            if (cur_stall) stall_cnt++;
            prev_stall = cur_stall;
            prev_s = s;
            prev_c = c_out;
            prev_o = ovf;
            prev_v = out_valid;
        end
    end

    task automatic send_check(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                              input logic xc, input logic xs,
                              input logic [15:0] ws, input logic wc, input logic wo);
        int n;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(S));
        chk({tag, "_s"}, 32'(s), 32'(ws));
        chk({tag, "_c_out"}, 32'(c_out), 32'(wc));
        chk({tag, "_ovf"}, 32'(ovf), 32'(wo));
        @(posedge clock); #1;
    endtask

    task automatic stream(input int n, input int stall_at, input int stall_len, input bit rnd);
        int sent = 0;
        int j = 0;
        while (sent < n && j < 400) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            if (rnd) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b1;
                out_ready = !(j >= stall_at && j < stall_at + stall_len);
            end
            @(negedge clock);
            if (in_valid && in_ready) sent++;
            @(posedge clock); #1;
            j++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(posedge clock); #1;
            k++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [17:0] dg_exp [DG_N + 16];
    bit          dg_v   [DG_N + 16];

    initial begin
        logic [17:0] r;
        int          base;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        dg_valid = 1'b0; dg_a = '0; dg_b = '0; dg_cin = 1'b0; dg_sub = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_s1_valid", 32'(o1_valid), 32'd0);
        chk("rst_s8_valid", 32'(o8_valid), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clock); #1;

        send_check("add",      16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0);
        send_check("sub_brw",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_check("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_check("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_check("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        stream(20, 1000, 0, 1'b0);
        drain();
        stream(20, 8, 3, 1'b0);
        drain();
        stream(60, 0, 0, 1'b1);
        drain();

        // Three tokens in flight, the oldest already presented at the output
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(posedge clock); #1;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        reset_n = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("post_reset_idle", 32'(out_valid), 32'd0);
        r = ref_model(W, 16'hA5C3, 16'h3C5A, 1'b1, 1'b0);
        send_check("post_rst", 16'hA5C3, 16'h3C5A, 1'b1, 1'b0, r[15:0], r[16], r[17]);
        drain();
        mon_en = 1'b0;

        // Degenerate 8-bit configurations share one sweep: a all values, b in steps of 17
        for (int idx = 0; idx < DG_N + 10; idx++) begin
            if (idx < DG_N) begin
                base     = idx / 4096;
                dg_a     = 8'(idx % 256);
                dg_b     = 8'(((idx / 256) % 16) * 17);
                dg_sub   = (base == 2);
                dg_cin   = (base == 1) ? 1'b1 : ((base == 2) ? 1'($urandom) : 1'b0);
                dg_valid = 1'b1;
                dg_exp[idx] = ref_model(8, {8'h00, dg_a}, {8'h00, dg_b}, dg_cin, dg_sub);
                dg_v[idx]   = 1'b1;
            end else begin
                dg_valid = 1'b0;
                dg_exp[idx] = '0;
                dg_v[idx]   = 1'b0;
            end
            @(negedge clock);
            chk("s1_valid", 32'(o1_valid), (idx >= 1) ? 32'(dg_v[idx-1]) : 32'd0);
            if (idx >= 1 && dg_v[idx-1]) begin
                chk("s1_s", 32'(o1_s), 32'(dg_exp[idx-1][7:0]));
                chk("s1_c_out", 32'(o1_c), 32'(dg_exp[idx-1][16]));
                chk("s1_ovf", 32'(o1_ovf), 32'(dg_exp[idx-1][17]));
            end
            chk("s8_valid", 32'(o8_valid), (idx >= 8) ? 32'(dg_v[idx-8]) : 32'd0);
            if (idx >= 8 && dg_v[idx-8]) begin
                chk("s8_s", 32'(o8_s), 32'(dg_exp[idx-8][7:0]));
                chk("s8_c_out", 32'(o8_c), 32'(dg_exp[idx-8][16]));
                chk("s8_ovf", 32'(o8_ovf), 32'(dg_exp[idx-8][17]));
            end
            @(posedge clock); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
